// File: rtl/msg_send_ctrl_pkg.sv
// Shared types and word-geometry constants for the message-send controller.
package msg_pkg;

  localparam int MSG_DATA_W     = 32;
  localparam int BYTES_PER_WORD = MSG_DATA_W / 8;
  localparam int LANE_W         = $clog2(BYTES_PER_WORD);
  localparam int WORD_CNT_W     = LANE_W + 1;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FETCH     = 3'd1,
    WAIT_DATA = 3'd2,
    SEND      = 3'd3,
    DONE      = 3'd4
  } state_e;

  // Bytes carried by the next word: a full word, or only the tail of the message.
  function automatic logic [WORD_CNT_W-1:0] word_bytes(input int unsigned remaining);
    if (remaining >= BYTES_PER_WORD)
      return WORD_CNT_W'(BYTES_PER_WORD);
    else
      return WORD_CNT_W'(remaining);
  endfunction

endpackage

// File: rtl/msg_send_ctrl_mem_port_arb.sv
// Shared data-memory port arbiter: CPU has priority, but the controller is
// forced through after MAX_WAIT consecutive denied fetch cycles.
module mem_port_arb
  import msg_pkg::*;
#(
  parameter int ADDR_W   = 8,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_ctrl_req,
  input  logic [ADDR_W-1:0] i_cur_addr,
  input  logic              i_cpu_mem_req,
  input  logic [ADDR_W-1:0] i_cpu_mem_addr,
  output logic              o_grant,
  output logic              o_cpu_stall,
  output logic [ADDR_W-1:0] o_mem_addr
);

  localparam int CNT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

  logic [CNT_W-1:0] r_wait_cnt;
  logic             w_forced;

  assign w_forced    = i_ctrl_req && i_cpu_mem_req && (r_wait_cnt == CNT_W'(MAX_WAIT));
  assign o_grant     = i_ctrl_req && (!i_cpu_mem_req || w_forced);
  assign o_cpu_stall = w_forced;
  assign o_mem_addr  = o_grant ? i_cur_addr : i_cpu_mem_addr;

  // Counts consecutive denied fetch cycles; any grant or idle cycle restarts it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait_cnt <= '0;
    end else if (!i_ctrl_req || o_grant) begin
      r_wait_cnt <= '0;
    end else if (r_wait_cnt != CNT_W'(MAX_WAIT)) begin
      r_wait_cnt <= r_wait_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/msg_send_ctrl.sv
// Message-send controller: fetches message words over the shared memory port
// and streams them out little-endian, one byte per valid/ready handshake.
module msg_send_ctrl
  import msg_pkg::*;
#(
  parameter int ADDR_W   = 8,
  parameter int LEN_W    = 8,
  parameter int DATA_W   = MSG_DATA_W,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              cpu_mem_req,
  input  logic [ADDR_W-1:0] cpu_mem_addr,
  output logic              cpu_stall,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              tx_valid,
  output logic [7:0]        tx_data,
  input  logic              tx_ready,
  output logic              busy,
  output logic              done
);

  state_e                  r_state;
  state_e                  w_next;
  logic [ADDR_W-1:0]       r_cur_addr;
  logic [LEN_W-1:0]        r_remaining;
  logic [WORD_CNT_W-1:0]   r_word_left;
  logic [DATA_W-1:0]       r_shift;

  logic                    w_ctrl_req;
  logic                    w_grant;
  logic                    w_handshake;
  logic                    w_last_byte;
  logic                    w_word_end;

  assign w_ctrl_req  = (r_state == FETCH);
  assign w_handshake = (r_state == SEND) && tx_ready;
  assign w_last_byte = (r_remaining == LEN_W'(1));
  assign w_word_end  = (r_word_left == WORD_CNT_W'(1));

  mem_port_arb #(
    .ADDR_W   (ADDR_W),
    .MAX_WAIT (MAX_WAIT)
  ) u_arb (
    .clk            (clk),
    .rst_n          (rst),
    .i_ctrl_req     (w_ctrl_req),
    .i_cur_addr     (r_cur_addr),
    .i_cpu_mem_req  (cpu_mem_req),
    .i_cpu_mem_addr (cpu_mem_addr),
    .o_grant        (w_grant),
    .o_cpu_stall    (cpu_stall),
    .o_mem_addr     (mem_addr)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    cmd_ready = 1'b0;
    tx_valid  = 1'b0;
    tx_data   = 8'h00;
    busy      = 1'b1;
    done      = 1'b0;
    case (r_state)
      IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid) begin
          w_next = (cmd_len == '0) ? DONE : FETCH;
        end
      end
      FETCH: begin
        if (w_grant) begin
          w_next = WAIT_DATA;
        end
      end
      WAIT_DATA: begin
        w_next = SEND;
      end
      SEND: begin
        tx_valid = 1'b1;
        tx_data  = r_shift[7:0];
        if (w_handshake) begin
          if (w_last_byte) begin
            w_next = DONE;
          end else if (w_word_end) begin
            w_next = FETCH;
          end
        end
      end
      DONE: begin
        done   = 1'b1;
        w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // Byte shifter: the current lane always sits in bits [7:0].
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cur_addr  <= '0;
      r_remaining <= '0;
      r_word_left <= '0;
      r_shift     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (cmd_valid) begin
            r_cur_addr  <= cmd_addr;
            r_remaining <= cmd_len;
          end
        end
        WAIT_DATA: begin
          r_shift     <= mem_rdata;
          r_word_left <= word_bytes(32'(r_remaining));
        end
        SEND: begin
          if (w_handshake) begin
            r_remaining <= r_remaining - LEN_W'(1);
            r_word_left <= r_word_left - WORD_CNT_W'(1);
            r_shift     <= r_shift >> 8;
            if (!w_last_byte && w_word_end) begin
              r_cur_addr <= r_cur_addr + ADDR_W'(1);
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
